// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED pattern generator (off/on/blink/counted burst)
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   enable            global LED output enable (internal schedule keeps running)
//   cfg_we            one-cycle channel configuration write strobe
//   cfg_ch            target channel; values >= NUM_LEDS match no channel
//   cfg_mode          0=OFF 1=ON 2=BLINK 3=BURST
//   cfg_half_period   ticks per on phase and per off phase (0 behaves as 1)
//   cfg_burst         on/off cycles for BURST
//   led               lit & enable per channel
//   busy              channel is in BLINK or BURST
//   done              registered one-cycle pulse when a BURST completes
module led_pattern_gen #(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 250_000,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half_period,
  input  logic [CNT_W-1:0]    cfg_burst,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] busy,
  output logic [NUM_LEDS-1:0] done
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  // Shared free-running prescaler; never disturbed by configuration writes.
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  assign tick = (ps_q == PS_W'(TICK_DIV - 1));

  always_comb begin
    ps_d = ps_q + PS_W'(1);
    if (tick) begin
      ps_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    mode_e            mode_q, mode_d;
    logic             lit_q, lit_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             sel;
    mode_e            wr_mode;

    assign sel     = cfg_we && (cfg_ch == CH_W'(i));
    assign wr_mode = mode_e'(cfg_mode);

    always_comb begin
      mode_d  = mode_q;
      lit_d   = lit_q;
      phase_d = phase_q;
      half_d  = half_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      // A write takes priority over a coincident tick, so that tick is lost.
      if (sel) begin
        mode_d  = wr_mode;
        half_d  = (cfg_half_period == '0) ? CNT_W'(1) : cfg_half_period;
        phase_d = '0;
        rem_d   = cfg_burst;
        lit_d   = (wr_mode != MODE_OFF);
        // An empty burst completes immediately.
        if (wr_mode == MODE_BURST && cfg_burst == '0) begin
          mode_d = MODE_OFF;
          lit_d  = 1'b0;
          done_d = 1'b1;
        end
      end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
        if (phase_q == half_q - CNT_W'(1)) begin
          phase_d = '0;
          lit_d   = ~lit_q;
          // Bursts are counted on falling toggles; the last one ends the burst.
          if (mode_q == MODE_BURST && lit_q) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              mode_d = MODE_OFF;
              lit_d  = 1'b0;
              done_d = 1'b1;
            end
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q  <= MODE_OFF;
        lit_q   <= 1'b0;
        phase_q <= '0;
        half_q  <= CNT_W'(1);
        rem_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        lit_q   <= lit_d;
        phase_q <= phase_d;
        half_q  <= half_d;
        rem_q   <= rem_d;
        done_q  <= done_d;
      end
    end

    assign led[i]  = lit_q & enable;
    assign busy[i] = (mode_q == MODE_BLINK) || (mode_q == MODE_BURST);
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_half_period = 8'd1;
  logic [7:0] cfg_burst = '0;
  logic [3:0] led, busy, done;
  logic [2:0] led3, busy3, done3;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LEDS(4), .TICK_DIV(TD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period), .cfg_burst(cfg_burst),
    .led(led), .busy(busy), .done(done)
  );

  // Three-channel instance: cfg_ch=3 is out of range for it and must be ignored.
  led_pattern_gen #(.NUM_LEDS(3), .TICK_DIV(TD), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period), .cfg_burst(cfg_burst),
    .led(led3), .busy(busy3), .done(done3)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: per channel, ticks elapsed since the last write.
  int m_mode[4];
  int m_half[4];
  int m_burst[4];
  int m_t[4];
  bit m_done[4];
  int pc;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit m_lit(input int i);
    if (m_mode[i] == 0) return 1'b0;
    if (m_mode[i] == 1) return 1'b1;
    return ((m_t[i] / m_half[i]) % 2) == 0;
  endfunction

  task automatic model_edge();
    bit tk;
    tk = (pc % TD) == TD - 1;
    if (rst) begin
      pc = 0;
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 0; m_half[i] = 1; m_burst[i] = 0; m_t[i] = 0; m_done[i] = 0;
      end
      return;
    end
    pc = (pc + 1) % TD;
    for (int i = 0; i < 4; i++) begin
      m_done[i] = 0;
      if (cfg_we && int'(cfg_ch) == i) begin
        m_mode[i]  = int'(cfg_mode);
        m_half[i]  = (cfg_half_period == 0) ? 1 : int'(cfg_half_period);
        m_burst[i] = int'(cfg_burst);
        m_t[i]     = 0;
        if (m_mode[i] == 3 && m_burst[i] == 0) begin
          m_mode[i] = 0; m_done[i] = 1;
        end
      end else if (tk && m_mode[i] >= 2) begin
        m_t[i]++;
        if (m_mode[i] == 3 && m_t[i] == (2 * m_burst[i] - 1) * m_half[i]) begin
          m_mode[i] = 0; m_done[i] = 1;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] el, eb, ed;
    for (int i = 0; i < 4; i++) begin
      el[i] = m_lit(i) & enable;
      eb[i] = m_mode[i] >= 2;
      ed[i] = m_done[i];
    end
    chk({tag, "_led"}, led, el);
    chk({tag, "_busy"}, busy, eb);
    chk({tag, "_done"}, done, ed);
    chk({tag, "_led3"}, led3, el[2:0]);
    chk({tag, "_busy3"}, busy3, eb[2:0]);
    chk({tag, "_done3"}, done3, ed[2:0]);
  endtask

  task automatic wr(input int ch, input int mode, input int half, input int burst);
    cfg_we = 1'b1;
    cfg_ch = 2'(ch);
    cfg_mode = 2'(mode);
    cfg_half_period = 8'(half);
    cfg_burst = 8'(burst);
    step();
    cfg_we = 1'b0;
    check_model("wr");
  endtask

  task automatic wait_level(input int ch, input bit val, input string name);
    int n = 0;
    while (led[ch] != val && n < 64) begin
      step(); check_model(name); n++;
    end
    chk({name, "_wait"}, int'(led[ch]), int'(val));
  endtask

  task automatic measure_run(input int ch, input string name, output int len);
    logic lvl;
    lvl = led[ch];
    len = 0;
    while (led[ch] == lvl && len < 64) begin
      len++; step(); check_model(name);
    end
  endtask

  typedef struct {
    bit         we;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [7:0] half;
    logic [7:0] burst;
    bit         en;
    logic [3:0] e_led;
    logic [3:0] e_busy;
    logic [3:0] e_done;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int len, cnt;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0; m_half[i] = 1; m_burst[i] = 0; m_t[i] = 0; m_done[i] = 0;
    end
    pc = 0;

    tbl[0]  = '{0, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1, 2, 1, 1, 0, 1, 4'b0100, 4'b0000, 4'b0000};
    tbl[2]  = '{1, 0, 2, 3, 0, 1, 4'b0101, 4'b0001, 4'b0000};
    tbl[3]  = '{1, 1, 3, 1, 0, 1, 4'b0101, 4'b0001, 4'b0010};
    tbl[4]  = '{1, 1, 1, 1, 0, 1, 4'b0111, 4'b0001, 4'b0000};
    tbl[5]  = '{1, 1, 0, 1, 0, 1, 4'b0101, 4'b0001, 4'b0000};
    tbl[6]  = '{1, 3, 3, 5, 2, 1, 4'b1101, 4'b1001, 4'b0000};
    tbl[7]  = '{0, 0, 0, 1, 0, 0, 4'b0000, 4'b1001, 4'b0000};
    tbl[8]  = '{1, 2, 0, 1, 0, 0, 4'b0000, 4'b1001, 4'b0000};
    tbl[9]  = '{0, 0, 0, 1, 0, 1, 4'b1001, 4'b1001, 4'b0000};
    tbl[10] = '{1, 3, 0, 1, 0, 1, 4'b0001, 4'b0001, 4'b0000};
    tbl[11] = '{1, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000};

    rst = 1'b1;
    step(); step();
    chk("reset_led", led, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      cfg_we = tbl[k].we;
      cfg_ch = tbl[k].ch;
      cfg_mode = tbl[k].mode;
      cfg_half_period = tbl[k].half;
      cfg_burst = tbl[k].burst;
      enable = tbl[k].en;
      step();
      cfg_we = 1'b0;
      chk($sformatf("tbl%0d_led", k), led, tbl[k].e_led);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].e_busy);
      chk($sformatf("tbl%0d_done", k), done, tbl[k].e_done);
      check_model($sformatf("tbl%0d", k));
    end
    enable = 1'b1;

    // BLINK half=3: 12-cycle phases after the first toggle.
    wr(0, 2, 3, 0);
    wait_level(0, 1'b0, "blink_fall");
    cnt = 0;
    for (int r = 0; r < 8; r++) begin
      measure_run(0, "blink", len);
      chk($sformatf("blink_run%0d", r), len, 12);
      if (busy[0] !== 1'b1 || done[0] !== 1'b0) cnt++;
    end
    chk("blink_busy_done", cnt, 0);
    wr(0, 0, 1, 0);

    // BURST half=1 burst=2: done coincides with the final fall.
    wr(1, 3, 1, 2);
    measure_run(1, "burst", len);
    chk("burst_first_hi_range", int'(len >= 1 && len <= 4), 1);
    chk("burst_first_fall_nodone", done[1], 0);
    measure_run(1, "burst", len);
    chk("burst_low", len, 4);
    measure_run(1, "burst", len);
    chk("burst_second_hi", len, 4);
    chk("burst_done_at_fall", done[1], 1);
    chk("burst_busy_at_fall", busy[1], 0);
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step(); check_model("burst_after");
      cnt += int'(led[1]) + int'(done[1]);
    end
    chk("burst_quiet_after", cnt, 0);

    // Abort mid-burst with the write on a tick cycle; ch3 blinks alongside.
    wr(3, 2, 2, 0);
    wr(1, 3, 1, 5);
    for (int c = 0; c < 7; c++) begin step(); check_model("abort_pre"); end
    while (pc % TD != TD - 1) begin step(); check_model("abort_align"); end
    wr(1, 0, 1, 0);
    chk("abort_led", led[1], 0);
    chk("abort_busy", busy[1], 0);
    cnt = 0;
    for (int c = 0; c < 24; c++) begin
      step(); check_model("abort_after");
      cnt += int'(done[1]);
    end
    chk("abort_no_done", cnt + int'(done[1]), 0);
    wr(3, 0, 1, 0);

    // enable gating on BLINK half=2.
    wr(0, 2, 2, 0);
    for (int c = 0; c < 10; c++) begin step(); check_model("en_pre"); end
    enable = 1'b0;
    #1;
    for (int c = 0; c < 20; c++) begin
      chk("en_low_led", led, 0);
      step(); check_model("en_low");
    end
    enable = 1'b1;
    #1;
    for (int c = 0; c < 40; c++) begin step(); check_model("en_post"); end

    // half=0 behaves as half=1.
    wr(0, 2, 0, 0);
    wait_level(0, 1'b0, "h0_fall");
    for (int r = 0; r < 4; r++) begin
      measure_run(0, "h0", len);
      chk($sformatf("h0_run%0d", r), len, 4);
    end

    // Reset in the middle of a burst.
    wr(2, 3, 1, 3);
    for (int c = 0; c < 5; c++) begin step(); check_model("rst_pre"); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_led", led, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    for (int c = 0; c < 12; c++) begin step(); check_model("midrst_after"); end

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_half_period = 8'($urandom_range(0, 3));
      cfg_burst = 8'($urandom_range(0, 3));
      enable = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
